// File: rtl/fetch_pair_pkg.sv
// fetch_pair shared definitions: exception tags, fetch FSM states,
// reset PC, kseg1 segment and address helpers.
package fetch_pair_pkg;

  localparam logic [31:0] RESET_PC = 32'hBFC0_0000;
  localparam logic [2:0]  KSEG1    = 3'b101;

  localparam logic [1:0] IEXC_NONE = 2'd1;
  localparam logic [1:0] IEXC_ADEL = 2'd2;

  typedef enum logic [1:0] {
    IDLE,
    REQ,
    WAIT,
    HALT
  } fetch_state_t;

  function automatic logic is_cached(
    input logic [31:0] a
  );
    return a[31:29] != KSEG1;
  endfunction

  function automatic logic [31:0] pair_base(
    input logic [31:0] a
  );
    return {a[31:3], 3'b000};
  endfunction

endpackage

// File: rtl/fetch_pair.sv
// fetch_pair: fetch stage feeding the dual-issue FIFO. One outstanding
// aligned-pair request (ic_*), pushes 1-2 instructions per response.
// Ports: clk, reset (sync, high), redirect/redirectPc, fifoFull,
//   ic_req/ic_addr/ic_cached/ic_addrOk/ic_dataOk/ic_rdata,
//   pc/inst1/inst2/write1En/write2En/iexcep/cached to the FIFO.
// Option FETCH_PERF_CNT_EN adds perfPairCnt and perfFullCnt.
module fetch_pair
  import fetch_pair_pkg::*;
(
  input  logic        clk,
  input  logic        reset,
  input  logic        redirect,
  input  logic [31:0] redirectPc,
  input  logic        fifoFull,
  output logic        ic_req,
  output logic [31:0] ic_addr,
  output logic        ic_cached,
  input  logic        ic_addrOk,
  input  logic        ic_dataOk,
  input  logic [63:0] ic_rdata,
  output logic [31:0] pc,
  output logic [31:0] inst1,
  output logic [31:0] inst2,
  output logic        write1En,
  output logic        write2En,
  output logic [1:0]  iexcep,
  output logic        cached
`ifdef FETCH_PERF_CNT_EN
  ,
  output logic [31:0] perfPairCnt,
  output logic [31:0] perfFullCnt
`endif
);

  fetch_state_t state;
  logic [31:0]  fetch_pc;
  logic         drop;

  always_ff @(posedge clk) begin
    if (reset) begin
      state     <= IDLE;
      fetch_pc  <= RESET_PC;
      drop      <= 1'b0;
      ic_req    <= 1'b0;
      ic_addr   <= '0;
      ic_cached <= 1'b0;
      pc        <= '0;
      inst1     <= '0;
      inst2     <= '0;
      write1En  <= 1'b0;
      write2En  <= 1'b0;
      iexcep    <= IEXC_NONE;
      cached    <= 1'b0;
`ifdef FETCH_PERF_CNT_EN
      perfPairCnt <= '0;
      perfFullCnt <= '0;
`endif
    end else begin
      write1En <= 1'b0;
      write2En <= 1'b0;
      unique case (state)
        IDLE: begin
          if (redirect) begin
            fetch_pc <= redirectPc;
          end else if (fetch_pc[1:0] != 2'b00) begin
            // Misaligned PC: tag one entry, stop fetching.
            write1En <= 1'b1;
            pc       <= fetch_pc;
            inst1    <= '0;
            inst2    <= '0;
            iexcep   <= IEXC_ADEL;
            cached   <= is_cached(fetch_pc);
            state    <= HALT;
          end else if (!fifoFull) begin
            ic_req    <= 1'b1;
            ic_addr   <= pair_base(fetch_pc);
            ic_cached <= is_cached(fetch_pc);
            state     <= REQ;
          end else begin
`ifdef FETCH_PERF_CNT_EN
            perfFullCnt <= perfFullCnt + 32'd1;
`endif
          end
        end
        REQ: begin
          // Request is never withdrawn; a redirect only
          // marks its eventual response as stale.
          if (ic_addrOk) begin
            ic_req <= 1'b0;
            state  <= WAIT;
          end
          if (redirect) begin
            fetch_pc <= redirectPc;
            drop     <= 1'b1;
          end
        end
        WAIT: begin
          if (ic_dataOk) begin
            state <= IDLE;
            drop  <= 1'b0;
            if (redirect) begin
              fetch_pc <= redirectPc;
            end else if (!drop) begin
              write1En <= 1'b1;
              write2En <= ~fetch_pc[2];
              pc       <= fetch_pc;
              inst1    <= fetch_pc[2] ? ic_rdata[63:32]
                                      : ic_rdata[31:0];
              inst2    <= fetch_pc[2] ? 32'd0
                                      : ic_rdata[63:32];
              iexcep   <= IEXC_NONE;
              cached   <= ic_cached;
              fetch_pc <= pair_base(fetch_pc) + 32'd8;
`ifdef FETCH_PERF_CNT_EN
              perfPairCnt <= perfPairCnt + 32'd1;
`endif
            end
          end else if (redirect) begin
            fetch_pc <= redirectPc;
            drop     <= 1'b1;
          end
        end
        HALT: begin
          if (redirect) begin
            fetch_pc <= redirectPc;
            state    <= IDLE;
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_fetch_pair.sv
// tb_fetch_pair: directed stimulus for fetch_pair with a transaction
// level model checked every cycle plus literal expectations.
module tb_fetch_pair;

  logic        clk;
  logic        reset;
  logic        redirect;
  logic [31:0] redirectPc;
  logic        fifoFull;
  logic        ic_req;
  logic [31:0] ic_addr;
  logic        ic_cached;
  logic        ic_addrOk;
  logic        ic_dataOk;
  logic [63:0] ic_rdata;
  logic [31:0] pc;
  logic [31:0] inst1;
  logic [31:0] inst2;
  logic        write1En;
  logic        write2En;
  logic [1:0]  iexcep;
  logic        cached;

  fetch_pair dut (
    .clk(clk),
    .reset(reset),
    .redirect(redirect),
    .redirectPc(redirectPc),
    .fifoFull(fifoFull),
    .ic_req(ic_req),
    .ic_addr(ic_addr),
    .ic_cached(ic_cached),
    .ic_addrOk(ic_addrOk),
    .ic_dataOk(ic_dataOk),
    .ic_rdata(ic_rdata),
    .pc(pc),
    .inst1(inst1),
    .inst2(inst2),
    .write1En(write1En),
    .write2En(write2En),
    .iexcep(iexcep),
    .cached(cached)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int checks = 0;
  int failures = 0;

  task automatic chk(
    input string       nm,
    input logic [63:0] act,
    input logic [63:0] exp
  );
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s actual=%h required=%h", nm, act, exp);
    end
  endtask

  // Model: architectural fetch PC, whether an accepted request is
  // outstanding, whether its response is stale, halted on ADEL.
  logic [31:0] mpc;
  logic        outst;
  logic        mdrop;
  logic        mhalt;
  logic        started = 1'b0;
  logic        exp_req;
  logic [31:0] exp_addr;
  logic        exp_icc;
  logic        exp_w1;
  logic        exp_w2;
  logic [31:0] exp_pc;
  logic [31:0] exp_i1;
  logic [31:0] exp_i2;
  logic [1:0]  exp_ex;
  logic        exp_c;

  always @(posedge clk) begin
    logic s_req;
    logic idle;
    logic was_outst;
    if (reset) begin
      started = 1'b1;
      mpc     = 32'hBFC0_0000;
      outst   = 1'b0;
      mdrop   = 1'b0;
      mhalt   = 1'b0;
      exp_req = 1'b0;
      exp_w1  = 1'b0;
      exp_w2  = 1'b0;
    end else begin
      s_req     = ic_req;
      was_outst = outst;
      idle      = !s_req && !outst && !mhalt;
      exp_w1    = 1'b0;
      exp_w2    = 1'b0;
      if (s_req && !ic_addrOk) begin
        exp_req = 1'b1;
      end else if (idle && !redirect && mpc[1:0] == 2'b00
                   && !fifoFull) begin
        exp_req  = 1'b1;
        exp_addr = mpc & 32'hFFFF_FFF8;
        exp_icc  = mpc[31:29] != 3'b101;
      end else begin
        exp_req = 1'b0;
      end
      if (outst && ic_dataOk) begin
        if (!mdrop && !redirect) begin
          exp_w1 = 1'b1;
          exp_w2 = !mpc[2];
          exp_pc = mpc;
          exp_i1 = mpc[2] ? ic_rdata[63:32] : ic_rdata[31:0];
          exp_i2 = mpc[2] ? 32'd0 : ic_rdata[63:32];
          exp_ex = 2'd1;
          exp_c  = mpc[31:29] != 3'b101;
          mpc    = (mpc & 32'hFFFF_FFF8) + 32'd8;
        end
        mdrop = 1'b0;
        outst = 1'b0;
      end
      if (idle && !redirect && mpc[1:0] != 2'b00) begin
        exp_w1 = 1'b1;
        exp_w2 = 1'b0;
        exp_pc = mpc;
        exp_i1 = 32'd0;
        exp_i2 = 32'd0;
        exp_ex = 2'd2;
        exp_c  = mpc[31:29] != 3'b101;
        mhalt  = 1'b1;
      end
      if (redirect) begin
        if ((s_req || was_outst) && !(was_outst && ic_dataOk))
          mdrop = 1'b1;
        mpc   = redirectPc;
        mhalt = 1'b0;
      end
      if (s_req && ic_addrOk) outst = 1'b1;
    end
  end

  always @(negedge clk) begin
    if (started) begin
      chk("m_req", {63'd0, ic_req}, {63'd0, exp_req});
      if (exp_req) begin
        chk("m_addr", {32'd0, ic_addr}, {32'd0, exp_addr});
        chk("m_icc", {63'd0, ic_cached}, {63'd0, exp_icc});
      end
      chk("m_w1", {63'd0, write1En}, {63'd0, exp_w1});
      chk("m_w2", {63'd0, write2En}, {63'd0, exp_w2});
      if (exp_w1) begin
        chk("m_pc", {32'd0, pc}, {32'd0, exp_pc});
        chk("m_i1", {32'd0, inst1}, {32'd0, exp_i1});
        chk("m_i2", {32'd0, inst2}, {32'd0, exp_i2});
        chk("m_ex", {62'd0, iexcep}, {62'd0, exp_ex});
        chk("m_c", {63'd0, cached}, {63'd0, exp_c});
      end
    end
  end

  task automatic cyc();
    @(posedge clk);
    #1;
  endtask

  task automatic wait_req();
    int n = 0;
    while (!ic_req && n < 20) begin
      cyc();
      n++;
    end
    chk("req_timeout", {63'd0, ic_req}, 64'd1);
  endtask

  task automatic accept();
    wait_req();
    ic_addrOk = 1'b1;
    cyc();
    ic_addrOk = 1'b0;
  endtask

  task automatic respond(input logic [63:0] d);
    ic_dataOk = 1'b1;
    ic_rdata  = d;
    cyc();
    ic_dataOk = 1'b0;
  endtask

  task automatic redir(input logic [31:0] a);
    redirect   = 1'b1;
    redirectPc = a;
    cyc();
    redirect = 1'b0;
  endtask

  initial begin
    reset      = 1'b1;
    redirect   = 1'b0;
    redirectPc = '0;
    fifoFull   = 1'b0;
    ic_addrOk  = 1'b0;
    ic_dataOk  = 1'b0;
    ic_rdata   = '0;
    cyc();
    cyc();
    chk("rst_req", {63'd0, ic_req}, 64'd0);
    chk("rst_addr", {32'd0, ic_addr}, 64'd0);
    chk("rst_w", {62'd0, write1En, write2En}, 64'd0);
    chk("rst_pc", {32'd0, pc}, 64'd0);
    chk("rst_inst", {inst2, inst1}, 64'd0);
    chk("rst_exc", {62'd0, iexcep}, 64'd1);
    chk("rst_cached", {63'd0, cached}, 64'd0);

    reset = 1'b0;
    cyc();
    chk("first_req", {63'd0, ic_req}, 64'd1);
    chk("first_addr", {32'd0, ic_addr}, 64'hBFC0_0000);
    chk("first_icc", {63'd0, ic_cached}, 64'd0);
    accept();
    respond(64'h2222_2222_1111_1111);
    chk("p0_w", {62'd0, write1En, write2En}, 64'd3);
    chk("p0_pc", {32'd0, pc}, 64'hBFC0_0000);
    chk("p0_inst", {inst2, inst1}, 64'h2222_2222_1111_1111);
    cyc();
    chk("p1_addr", {32'd0, ic_addr}, 64'hBFC0_0008);

    accept();
    redir(32'h8000_1000);
    respond(64'hDEAD_BEEF_DEAD_BEEF);
    chk("drop_wait", {63'd0, write1En}, 64'd0);
    wait_req();
    chk("redir_addr", {32'd0, ic_addr}, 64'h8000_1000);
    accept();
    respond(64'h4444_4444_3333_3333);
    chk("p2_pc", {32'd0, pc}, 64'h8000_1000);

    redir(32'h8000_0104);
    wait_req();
    chk("odd_addr", {32'd0, ic_addr}, 64'h8000_0100);
    chk("odd_icc", {63'd0, ic_cached}, 64'd1);
    accept();
    respond(64'h6666_6666_5555_5555);
    chk("odd_w", {62'd0, write1En, write2En}, 64'd2);
    chk("odd_inst", {inst2, inst1}, 64'h0000_0000_6666_6666);
    chk("odd_pc", {32'd0, pc}, 64'h8000_0104);

    fifoFull = 1'b1;
    for (int i = 0; i < 5; i++) begin
      cyc();
      chk("full_noreq", {63'd0, ic_req}, 64'd0);
    end
    fifoFull = 1'b0;
    cyc();
    chk("full_release", {63'd0, ic_req}, 64'd1);
    chk("full_addr", {32'd0, ic_addr}, 64'h8000_0108);

    accept();
    ic_dataOk  = 1'b1;
    ic_rdata   = 64'h7777_7777_7777_7777;
    redirect   = 1'b1;
    redirectPc = 32'h8000_2000;
    cyc();
    ic_dataOk = 1'b0;
    redirect  = 1'b0;
    chk("coinc_nowrite", {63'd0, write1En}, 64'd0);
    wait_req();
    chk("coinc_addr", {32'd0, ic_addr}, 64'h8000_2000);

    redir(32'h8000_3000);
    chk("req_hold", {32'd0, ic_addr}, 64'h8000_2000);
    accept();
    respond(64'h8888_8888_8888_8888);
    chk("req_drop", {63'd0, write1En}, 64'd0);
    wait_req();
    chk("req_redir_addr", {32'd0, ic_addr}, 64'h8000_3000);
    accept();
    respond(64'hAAAA_AAAA_9999_9999);

    redir(32'hFFFF_FFF8);
    accept();
    respond(64'hCCCC_CCCC_BBBB_BBBB);
    chk("top_pc", {32'd0, pc}, 64'hFFFF_FFF8);
    wait_req();
    chk("wrap_addr", {32'd0, ic_addr}, 64'd0);
    accept();
    respond(64'hEEEE_EEEE_DDDD_DDDD);

    redir(32'h8000_0002);
    cyc();
    chk("adel_w", {62'd0, write1En, write2En}, 64'd2);
    chk("adel_exc", {62'd0, iexcep}, 64'd2);
    chk("adel_pc", {32'd0, pc}, 64'h8000_0002);
    chk("adel_inst", {32'd0, inst1}, 64'd0);
    for (int i = 0; i < 4; i++) begin
      cyc();
      chk("halt_noreq", {63'd0, ic_req}, 64'd0);
    end
    redir(32'h8000_4000);
    wait_req();
    chk("halt_exit", {32'd0, ic_addr}, 64'h8000_4000);

    accept();
    reset = 1'b1;
    cyc();
    reset     = 1'b0;
    ic_dataOk = 1'b1;
    ic_rdata  = 64'h1234_5678_9ABC_DEF0;
    cyc();
    ic_dataOk = 1'b0;
    chk("stale_nowrite", {63'd0, write1En}, 64'd0);
    chk("stale_req", {63'd0, ic_req}, 64'd1);
    chk("stale_addr", {32'd0, ic_addr}, 64'hBFC0_0000);
    cyc();
    cyc();

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
